// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, write-enable constant and read-tag encoding for the memory port arbiter.
`default_nettype none

package mem_arb_pkg;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 32;

  localparam logic [3:0] WEA_NONE = 4'b0000;

  typedef enum logic [1:0] {
    TAG_NONE  = 2'b00,
    TAG_FETCH = 2'b01,
    TAG_DATA  = 2'b10
  } tag_t;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: RD_LAT-deep shift register of read owners, aligned with the memory read latency.
`default_nettype none

module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic flush,
  input  tag_t load_tag,
  output logic f_rvalid,
  output logic d_rvalid
);

  tag_t stage [RD_LAT];

  // The incoming tag is never flushed: a fetch granted alongside the flush is the redirect target.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage[i] <= TAG_NONE;
      end
    end else begin
      stage[0] <= load_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        stage[i] <= (flush && (stage[i-1] == TAG_FETCH)) ? TAG_NONE : stage[i-1];
      end
    end
  end

  assign f_rvalid = (stage[RD_LAT-1] == TAG_FETCH);
  assign d_rvalid = (stage[RD_LAT-1] == TAG_DATA);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous memory port between fetch and exec, with starvation guard.
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_wea,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_enable,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [3:0]        m_wea,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic [3:0] starve_cnt;
  logic       starved;
  tag_t       load_tag;

  assign starved = (starve_cnt == MAX_WAIT_C);

  // Exec has priority unless fetch has lost MAX_WAIT consecutive cycles.
  assign f_gnt = f_req & (~d_req | starved);
  assign d_gnt = d_req & ~f_gnt;

  assign m_enable = f_gnt | d_gnt;
  assign m_addr   = f_gnt ? f_addr : d_addr;
  assign m_wea    = d_gnt ? d_wea : WEA_NONE;
  assign m_wdata  = d_wdata;

  assign f_rdata = m_rdata;
  assign d_rdata = m_rdata;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= 4'd0;
    end else if (f_gnt) begin
      starve_cnt <= 4'd0;
    end else if (f_req && !starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_comb begin
    load_tag = TAG_NONE;
    if (f_gnt) begin
      load_tag = TAG_FETCH;
    end else if (d_gnt && (d_wea == WEA_NONE)) begin
      load_tag = TAG_DATA;
    end
  end

  rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (f_flush),
    .load_tag (load_tag),
    .f_rvalid (f_rvalid),
    .d_rvalid (d_rvalid)
  );

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiters (RD_LAT = 1, 2, 3) share stimulus, each with its own latency-matched memory.
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        f_req, f_flush, d_req;
  logic [18:0] f_addr, d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wea;

  logic [3:1]  f_gnt_a, f_rvalid_a, d_gnt_a, d_rvalid_a, m_en_a;
  logic [31:0] f_rdata_a [1:3];
  logic [31:0] d_rdata_a [1:3];
  logic [18:0] m_addr_a  [1:3];
  logic [31:0] m_wdata_a [1:3];
  logic [3:0]  m_wea_a   [1:3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar i = 1; i <= 3; i++) begin : g_lat
    logic [31:0] pipe [0:3];

    // Read data = address ^ A5A50000, returned i cycles after the enable.
    always @(posedge clk) begin
      pipe[0] <= (m_en_a[i] && m_wea_a[i] == 4'b0000) ? ({13'h0, m_addr_a[i]} ^ 32'hA5A50000) : 32'h0;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    mem_port_arbiter #(.RD_LAT(i), .MAX_WAIT(3)) u_dut (
      .clk(clk), .rstn(rstn),
      .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
      .f_gnt(f_gnt_a[i]), .f_rvalid(f_rvalid_a[i]), .f_rdata(f_rdata_a[i]),
      .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_wea(d_wea),
      .d_gnt(d_gnt_a[i]), .d_rvalid(d_rvalid_a[i]), .d_rdata(d_rdata_a[i]),
      .m_enable(m_en_a[i]), .m_addr(m_addr_a[i]), .m_wdata(m_wdata_a[i]),
      .m_wea(m_wea_a[i]), .m_rdata(pipe[i-1])
    );
  end

  task automatic idle();
    f_req = 1'b0; f_flush = 1'b0; d_req = 1'b0;
    f_addr = '0; d_addr = '0; d_wdata = '0; d_wea = 4'b0000;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; idle();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (f_rvalid_a !== 3'b000 || d_rvalid_a !== 3'b000) begin errors++;
      $display("FAIL reset_valid: f_rvalid=%b d_rvalid=%b want 000/000", f_rvalid_a, d_rvalid_a); end
    rstn = 1'b1;
    @(negedge clk);
    checks++; if (m_en_a[1] !== 1'b0 || m_wea_a[1] !== 4'b0000 || f_gnt_a[1] !== 1'b0 || d_gnt_a[1] !== 1'b0) begin errors++;
      $display("FAIL reset_idle: m_enable=%b m_wea=%b f_gnt=%b d_gnt=%b want 0/0000/0/0", m_en_a[1], m_wea_a[1], f_gnt_a[1], d_gnt_a[1]); end
    next_cycle();
  endtask

  task automatic test_reset_mid_read();
    d_req = 1'b1; d_addr = 19'h00030;
    @(negedge clk);
    checks++; if (d_gnt_a[1] !== 1'b1) begin errors++;
      $display("FAIL midrst_gnt: d_gnt=%b want 1", d_gnt_a[1]); end
    next_cycle();
    idle(); rstn = 1'b0;
    #1;
    checks++; if (d_rvalid_a !== 3'b000) begin errors++;
      $display("FAIL midrst_cleared: d_rvalid=%b want 000", d_rvalid_a); end
    repeat (2) next_cycle();
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (d_rvalid_a !== 3'b000 || f_rvalid_a !== 3'b000) begin errors++;
        $display("FAIL midrst_after c%0d: d_rvalid=%b f_rvalid=%b want 000/000", c, d_rvalid_a, f_rvalid_a); end
      next_cycle();
    end
  endtask

  task automatic test_exec_read();
    d_req = 1'b1; d_addr = 19'h00010; d_wea = 4'b0000;
    @(negedge clk);
    checks++; if (d_gnt_a[1] !== 1'b1 || f_gnt_a[1] !== 1'b0) begin errors++;
      $display("FAIL rd_gnt: d_gnt=%b f_gnt=%b want 1/0", d_gnt_a[1], f_gnt_a[1]); end
    checks++; if (m_en_a[1] !== 1'b1 || m_addr_a[1] !== 19'h00010 || m_wea_a[1] !== 4'b0000) begin errors++;
      $display("FAIL rd_mem: m_enable=%b m_addr=%h m_wea=%b want 1/00010/0000", m_en_a[1], m_addr_a[1], m_wea_a[1]); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (d_rvalid_a !== 3'b001 || f_rvalid_a !== 3'b000) begin errors++;
      $display("FAIL rd_lat1: d_rvalid=%b f_rvalid=%b want 001/000", d_rvalid_a, f_rvalid_a); end
    checks++; if (d_rdata_a[1] !== 32'hA5A50010) begin errors++;
      $display("FAIL rd_data1: d_rdata=%h want a5a50010", d_rdata_a[1]); end
    next_cycle();
    @(negedge clk);
    checks++; if (d_rvalid_a !== 3'b010 || d_rdata_a[2] !== 32'hA5A50010) begin errors++;
      $display("FAIL rd_lat2: d_rvalid=%b d_rdata=%h want 010/a5a50010", d_rvalid_a, d_rdata_a[2]); end
    next_cycle();
    @(negedge clk);
    checks++; if (d_rvalid_a !== 3'b100 || d_rdata_a[3] !== 32'hA5A50010) begin errors++;
      $display("FAIL rd_lat3: d_rvalid=%b d_rdata=%h want 100/a5a50010", d_rvalid_a, d_rdata_a[3]); end
    next_cycle();
  endtask

  task automatic test_store();
    d_req = 1'b1; d_addr = 19'h00020; d_wdata = 32'hDEADBEEF; d_wea = 4'b1111;
    @(negedge clk);
    checks++; if (d_gnt_a[1] !== 1'b1 || m_wea_a[1] !== 4'b1111 || m_wdata_a[1] !== 32'hDEADBEEF || m_addr_a[1] !== 19'h00020) begin errors++;
      $display("FAIL st_mem: d_gnt=%b m_wea=%b m_wdata=%h m_addr=%h want 1/1111/deadbeef/00020", d_gnt_a[1], m_wea_a[1], m_wdata_a[1], m_addr_a[1]); end
    next_cycle();
    idle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (d_rvalid_a !== 3'b000) begin errors++;
        $display("FAIL st_novalid c%0d: d_rvalid=%b want 000", c, d_rvalid_a); end
      next_cycle();
    end
  endtask

  task automatic test_starvation();
    logic exp_d;
    f_req = 1'b1; f_addr = 19'h00100; d_req = 1'b1; d_addr = 19'h00200;
    for (int c = 0; c < 8; c++) begin
      exp_d = ((c % 4) != 3);
      @(negedge clk);
      checks++; if (d_gnt_a[1] !== exp_d || f_gnt_a[1] !== !exp_d) begin errors++;
        $display("FAIL starve c%0d: d_gnt=%b f_gnt=%b want %b/%b", c, d_gnt_a[1], f_gnt_a[1], exp_d, !exp_d); end
      checks++; if (m_addr_a[1] !== (exp_d ? 19'h00200 : 19'h00100)) begin errors++;
        $display("FAIL starve_addr c%0d: m_addr=%h want %h", c, m_addr_a[1], exp_d ? 19'h00200 : 19'h00100); end
      next_cycle();
    end
    idle();
    repeat (5) next_cycle();
  endtask

  task automatic test_flush();
    f_req = 1'b1; f_addr = 19'h00040;                  // cycle 0
    @(negedge clk);
    checks++; if (f_gnt_a[1] !== 1'b1 || m_wea_a[1] !== 4'b0000 || m_addr_a[1] !== 19'h00040) begin errors++;
      $display("FAIL fl_gnt: f_gnt=%b m_wea=%b m_addr=%h want 1/0000/00040", f_gnt_a[1], m_wea_a[1], m_addr_a[1]); end
    next_cycle();
    f_addr = 19'h00041;                                // cycle 1
    next_cycle();
    f_addr = 19'h00042; f_flush = 1'b1;                // cycle 2
    @(negedge clk);
    checks++; if (f_rvalid_a !== 3'b011) begin errors++;
      $display("FAIL fl_c2: f_rvalid=%b want 011", f_rvalid_a); end
    next_cycle();
    idle();                                            // cycle 3
    @(negedge clk);
    checks++; if (f_rvalid_a !== 3'b001 || f_rdata_a[1] !== 32'hA5A50042) begin errors++;
      $display("FAIL fl_c3: f_rvalid=%b f_rdata1=%h want 001/a5a50042", f_rvalid_a, f_rdata_a[1]); end
    next_cycle();
    @(negedge clk);                                    // cycle 4
    checks++; if (f_rvalid_a !== 3'b010 || f_rdata_a[2] !== 32'hA5A50042) begin errors++;
      $display("FAIL fl_c4: f_rvalid=%b f_rdata2=%h want 010/a5a50042", f_rvalid_a, f_rdata_a[2]); end
    next_cycle();
    @(negedge clk);                                    // cycle 5
    checks++; if (f_rvalid_a !== 3'b100 || f_rdata_a[3] !== 32'hA5A50042) begin errors++;
      $display("FAIL fl_c5: f_rvalid=%b f_rdata3=%h want 100/a5a50042", f_rvalid_a, f_rdata_a[3]); end
    next_cycle();
    repeat (2) next_cycle();
  endtask

  task automatic test_mixed();
    d_req = 1'b1; d_addr = 19'h00050;                  // cycle 0
    next_cycle();
    idle(); f_req = 1'b1; f_addr = 19'h00051; f_flush = 1'b1;  // cycle 1
    @(negedge clk);
    checks++; if (f_gnt_a[1] !== 1'b1) begin errors++;
      $display("FAIL mx_fgnt: f_gnt=%b want 1", f_gnt_a[1]); end
    next_cycle();
    idle();                                            // cycle 2
    @(negedge clk);
    checks++; if (d_rvalid_a[2] !== 1'b1 || f_rvalid_a[2] !== 1'b0 || d_rdata_a[2] !== 32'hA5A50050) begin errors++;
      $display("FAIL mx_c2: d_rvalid=%b f_rvalid=%b d_rdata=%h want 1/0/a5a50050", d_rvalid_a[2], f_rvalid_a[2], d_rdata_a[2]); end
    next_cycle();
    @(negedge clk);                                    // cycle 3
    checks++; if (f_rvalid_a[2] !== 1'b1 || d_rvalid_a[2] !== 1'b0 || f_rdata_a[2] !== 32'hA5A50051) begin errors++;
      $display("FAIL mx_c3: f_rvalid=%b d_rvalid=%b f_rdata=%h want 1/0/a5a50051", f_rvalid_a[2], d_rvalid_a[2], f_rdata_a[2]); end
    checks++; if (d_rvalid_a[3] !== 1'b1) begin errors++;
      $display("FAIL mx_lat3_d: d_rvalid=%b want 1", d_rvalid_a[3]); end
    next_cycle();
    @(negedge clk);                                    // cycle 4
    checks++; if (f_rvalid_a[3] !== 1'b1 || f_rdata_a[3] !== 32'hA5A50051) begin errors++;
      $display("FAIL mx_lat3_f: f_rvalid=%b f_rdata=%h want 1/a5a50051", f_rvalid_a[3], f_rdata_a[3]); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_reset_mid_read();
    test_exec_read();
    test_store();
    test_starvation();
    test_flush();
    test_mixed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
